// File: rtl/wb_initiator_reg_slice.sv
// Registered Wishbone classic request/response slice in front of an interconnect
// target port: one transaction at a time, with a bounded wait for the response.
module wb_initiator_reg_slice #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   t_adr,
   input  logic [DATA_WIDTH-1:0]   t_dat_w,
   output logic [DATA_WIDTH-1:0]   t_dat_r,
   input  logic                    t_cyc,
   input  logic                    t_stb,
   input  logic                    t_we,
   input  logic [DATA_WIDTH/8-1:0] t_sel,
   output logic                    t_ack,
   output logic                    t_err,
   output logic [ADDR_WIDTH-1:0]   i_adr,
   output logic [DATA_WIDTH-1:0]   i_dat_w,
   input  logic [DATA_WIDTH-1:0]   i_dat_r,
   output logic                    i_cyc,
   output logic                    i_stb,
   output logic                    i_we,
   output logic [DATA_WIDTH/8-1:0] i_sel,
   input  logic                    i_ack,
   input  logic                    i_err,
   output logic                    timeout
);

   localparam int SW = DATA_WIDTH / 8;
   // A zero TIMEOUT still needs a legal one-bit counter even though it is never compared.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
   logic [DATA_WIDTH-1:0]   dat_w_q, dat_w_d;
   logic [SW-1:0]           sel_q, sel_d;
   logic                    we_q, we_d;
   logic                    cyc_q, cyc_d;
   logic [DATA_WIDTH-1:0]   dat_r_q, dat_r_d;
   logic                    ack_q, ack_d;
   logic                    err_q, err_d;
   logic                    to_q, to_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         adr_q   <= '0;
         dat_w_q <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         cyc_q   <= 1'b0;
         dat_r_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         dat_w_q <= dat_w_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         cyc_q   <= cyc_d;
         dat_r_q <= dat_r_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      dat_w_d = dat_w_q;
      sel_d   = sel_q;
      we_d    = we_q;
      cyc_d   = cyc_q;
      dat_r_d = dat_r_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      to_d    = 1'b0;

      case (state_q)
         IDLE: begin
            cyc_d = 1'b0;
            if (t_cyc && t_stb) begin
               adr_d   = t_adr;
               dat_w_d = t_dat_w;
               sel_d   = t_sel;
               we_d    = t_we;
               cyc_d   = 1'b1;
               cnt_d   = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            cnt_d = cnt_q + CW'(1);
            // Abort beats any response that lands in the same cycle.
            if (!t_cyc) begin
               cyc_d   = 1'b0;
               state_d = IDLE;
            end else if (i_ack || i_err) begin
               if (i_ack && !we_q) dat_r_d = i_dat_r;
               err_d   = i_err;
               ack_d   = i_ack && !i_err;
               cyc_d   = 1'b0;
               state_d = RSP;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               err_d   = 1'b1;
               dat_r_d = '0;
               to_d    = 1'b1;
               cyc_d   = 1'b0;
               state_d = RSP;
            end
         end
         RSP: begin
            state_d = IDLE;
         end
         default: begin
            cyc_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign i_adr   = adr_q;
   assign i_dat_w = dat_w_q;
   assign i_sel   = sel_q;
   assign i_we    = we_q;
   assign i_cyc   = cyc_q;
   assign i_stb   = cyc_q;
   assign t_dat_r = dat_r_q;
   assign t_ack   = ack_q;
   assign t_err   = err_q;
   assign timeout = to_q;

endmodule

// File: tb/tb_wb_initiator_reg_slice.sv
// Directed bench for wb_initiator_reg_slice: per-cycle vector table plus
// hand-written abort, back-to-back and asynchronous-reset sequences.
module tb_wb_initiator_reg_slice;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] t_adr = '0, t_dat_w = '0, t_dat_r;
   logic        t_cyc = 1'b0, t_stb = 1'b0, t_we = 1'b0;
   logic [3:0]  t_sel = '0;
   logic        t_ack, t_err;
   logic [31:0] i_adr, i_dat_w, i_dat_r = '0;
   logic        i_cyc, i_stb, i_we;
   logic [3:0]  i_sel;
   logic        i_ack = 1'b0, i_err = 1'b0;
   logic        timeout;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   wb_initiator_reg_slice #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
      .clock(clock), .reset(reset),
      .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(t_dat_r),
      .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_sel(t_sel),
      .t_ack(t_ack), .t_err(t_err),
      .i_adr(i_adr), .i_dat_w(i_dat_w), .i_dat_r(i_dat_r),
      .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_sel(i_sel),
      .i_ack(i_ack), .i_err(i_err), .timeout(timeout)
   );

   typedef logic [105:0] obs_t;

   typedef struct {
      string       name;
      logic        cyc, stb, we;
      logic [31:0] adr, dw;
      logic [3:0]  sel;
      logic        ack, err;
      logic [31:0] dr;
      obs_t        exp;
   } vec_t;

   function automatic obs_t mk_exp(input logic icyc, input logic iwe, input logic [31:0] iadr,
                                   input logic [31:0] idw, input logic [3:0] isel,
                                   input logic tack, input logic terr, input logic [31:0] tdr,
                                   input logic to);
      return {icyc, icyc, iwe, iadr, idw, isel, tack, terr, tdr, to};
   endfunction

   function automatic vec_t V(input string nm, input logic cyc, input logic stb, input logic we,
                              input logic [31:0] adr, input logic [31:0] dw, input logic [3:0] sel,
                              input logic ack, input logic err, input logic [31:0] dr,
                              input logic icyc, input logic iwe, input logic [31:0] iadr,
                              input logic [31:0] idw, input logic [3:0] isel,
                              input logic tack, input logic terr, input logic [31:0] tdr,
                              input logic to);
      vec_t v;
      v.name = nm; v.cyc = cyc; v.stb = stb; v.we = we; v.adr = adr; v.dw = dw; v.sel = sel;
      v.ack = ack; v.err = err; v.dr = dr;
      v.exp = mk_exp(icyc, iwe, iadr, idw, isel, tack, terr, tdr, to);
      return v;
   endfunction

   function automatic obs_t obs();
      return {i_cyc, i_stb, i_we, i_adr, i_dat_w, i_sel, t_ack, t_err, t_dat_r, timeout};
   endfunction

   task automatic check(input string nm, input obs_t exp);
      obs_t got;
      got = obs();
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are checked 1 unit after the next edge.
   task automatic step(input vec_t v);
      t_cyc = v.cyc; t_stb = v.stb; t_we = v.we; t_adr = v.adr; t_dat_w = v.dw; t_sel = v.sel;
      i_ack = v.ack; i_err = v.err; i_dat_r = v.dr;
      @(posedge clock);
      #1;
      check(v.name, v.exp);
   endtask

   localparam logic [31:0] A1 = 32'h1000_0010, A2 = 32'h2000_0004, A3 = 32'h3000_0000;
   localparam logic [31:0] A4 = 32'h0000_0008, A5 = 32'h4000_0000, A6 = 32'h5000_0000;
   localparam logic [31:0] B1 = 32'h6000_0000, B2 = 32'h6000_0004, C1 = 32'h7000_0000;
   localparam logic [31:0] WD = 32'h1234_5678, RD = 32'hDEAD_BEEF, RD2 = 32'h2222_2222;

   vec_t tbl[22];

   initial begin
      // zero-wait read
      tbl[0]  = V("rd_req",   1,1,0,A1,0,4'hF, 0,0,0,            1,0,A1,0,4'hF, 0,0,0,0);
      tbl[1]  = V("rd_ack",   1,1,0,A1,0,4'hF, 1,0,RD,           0,0,A1,0,4'hF, 1,0,RD,0);
      tbl[2]  = V("rd_done",  0,0,0,0,0,4'h0,  0,0,0,            0,0,A1,0,4'hF, 0,0,RD,0);
      // write, three wait states; ack lands on the last cycle before expiry
      tbl[3]  = V("wr_req",   1,1,1,A2,WD,4'h3, 0,0,0,           1,1,A2,WD,4'h3, 0,0,RD,0);
      tbl[4]  = V("wr_ws1",   1,1,1,A2,WD,4'h3, 0,0,0,           1,1,A2,WD,4'h3, 0,0,RD,0);
      tbl[5]  = V("wr_ws2",   1,1,1,A2,WD,4'h3, 0,0,0,           1,1,A2,WD,4'h3, 0,0,RD,0);
      tbl[6]  = V("wr_ws3",   1,1,1,A2,WD,4'h3, 0,0,0,           1,1,A2,WD,4'h3, 0,0,RD,0);
      tbl[7]  = V("wr_ack",   1,1,1,A2,WD,4'h3, 1,0,32'hCAFEF00D, 0,1,A2,WD,4'h3, 1,0,RD,0);
      tbl[8]  = V("wr_done",  0,0,0,0,0,4'h0,   0,0,0,           0,1,A2,WD,4'h3, 0,0,RD,0);
      // decode error
      tbl[9]  = V("de_req",   1,1,0,A3,0,4'hF, 0,0,0,            1,0,A3,0,4'hF, 0,0,RD,0);
      tbl[10] = V("de_err",   1,1,0,A3,0,4'hF, 0,1,32'h11111111, 0,0,A3,0,4'hF, 0,1,RD,0);
      tbl[11] = V("de_done",  0,0,0,0,0,4'h0,  0,0,0,            0,0,A3,0,4'hF, 0,0,RD,0);
      // ack and err together: err wins, read data still captured because ack & !we
      tbl[12] = V("ae_req",   1,1,0,A4,0,4'hF, 0,0,0,            1,0,A4,0,4'hF, 0,0,RD,0);
      tbl[13] = V("ae_both",  1,1,0,A4,0,4'hF, 1,1,RD2,          0,0,A4,0,4'hF, 0,1,RD2,0);
      tbl[14] = V("ae_done",  0,0,0,0,0,4'h0,  0,0,0,            0,0,A4,0,4'hF, 0,0,RD2,0);
      // silent target, TIMEOUT=4: i_stb high for exactly 4 cycles
      tbl[15] = V("to_req",   1,1,0,A5,0,4'hF, 0,0,0,            1,0,A5,0,4'hF, 0,0,RD2,0);
      tbl[16] = V("to_w1",    1,1,0,A5,0,4'hF, 0,0,0,            1,0,A5,0,4'hF, 0,0,RD2,0);
      tbl[17] = V("to_w2",    1,1,0,A5,0,4'hF, 0,0,0,            1,0,A5,0,4'hF, 0,0,RD2,0);
      tbl[18] = V("to_w3",    1,1,0,A5,0,4'hF, 0,0,0,            1,0,A5,0,4'hF, 0,0,RD2,0);
      tbl[19] = V("to_fire",  1,1,0,A5,0,4'hF, 0,0,0,            0,0,A5,0,4'hF, 0,1,0,1);
      tbl[20] = V("to_late1", 0,0,0,0,0,4'h0,  1,0,32'h99999999, 0,0,A5,0,4'hF, 0,0,0,0);
      tbl[21] = V("to_late2", 0,0,0,0,0,4'h0,  1,0,32'h99999999, 0,0,A5,0,4'hF, 0,0,0,0);

      #3;
      check("reset_state", '0);
      #20 reset = 1'b1;
      @(posedge clock);
      #1;

      for (int k = 0; k < 22; k++) step(tbl[k]);

      // abort: t_cyc dropped in REQ, simultaneous ack ignored
      step(V("ab_req",    1,1,0,A6,0,4'hF, 0,0,0,            1,0,A6,0,4'hF, 0,0,0,0));
      step(V("ab_drop",   0,0,0,0,0,4'h0,  1,0,32'h77777777, 0,0,A6,0,4'hF, 0,0,0,0));
      step(V("ab_norsp",  0,0,0,0,0,4'h0,  0,0,0,            0,0,A6,0,4'hF, 0,0,0,0));

      // back-to-back: stb held through RSP is only sampled in the following IDLE cycle
      step(V("bb_req1",   1,1,0,B1,0,4'hF, 0,0,0,            1,0,B1,0,4'hF, 0,0,0,0));
      step(V("bb_ack1",   1,1,0,B1,0,4'hF, 1,0,32'hAAAA0001, 0,0,B1,0,4'hF, 1,0,32'hAAAA0001,0));
      step(V("bb_rsp",    1,1,0,B2,0,4'hF, 0,0,0,            0,0,B1,0,4'hF, 0,0,32'hAAAA0001,0));
      step(V("bb_req2",   1,1,0,B2,0,4'hF, 0,0,0,            1,0,B2,0,4'hF, 0,0,32'hAAAA0001,0));
      step(V("bb_ack2",   1,1,0,B2,0,4'hF, 1,0,32'hBBBB0002, 0,0,B2,0,4'hF, 1,0,32'hBBBB0002,0));
      step(V("bb_done",   0,0,0,0,0,4'h0,  0,0,0,            0,0,B2,0,4'hF, 0,0,32'hBBBB0002,0));

      // reset asserted mid-REQ clears everything without waiting for a clock edge
      step(V("rs_req",    1,1,1,C1,32'h55AA55AA,4'hC, 0,0,0, 1,1,C1,32'h55AA55AA,4'hC, 0,0,32'hBBBB0002,0));
      #2 reset = 1'b0;
      #1 check("rs_async", '0);
      t_cyc = 1'b0; t_stb = 1'b0; i_ack = 1'b1; i_err = 1'b1;
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1 check("rs_post1", '0);
      @(posedge clock);
      #1 check("rs_post2", '0);
      i_ack = 1'b0; i_err = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_initiator_reg_slice.md
Name: wb_initiator_reg_slice

Overview:
Registered Wishbone (classic) request/response slice that sits directly upstream of a target port of the combinational 2x2 interconnect. It breaks the combinational path from an initiator (CPU or DMA) into the interconnect and its decode logic. It also bounds every transaction with a timeout: a target that never acks or errs gets an error back to the initiator instead of a hang. It handles one transaction at a time (non-pipelined).

Parameters:
- ADDR_WIDTH, 32, width of the adr buses.
- DATA_WIDTH, 32, width of the data buses; sel width is DATA_WIDTH/8.
- TIMEOUT, 255, cycles spent in REQ before a timeout error is forced; 0 disables the timeout.

Ports:
- clock  in  1  single clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- t_adr  in  ADDR_WIDTH  address from upstream initiator.
- t_dat_w  in  DATA_WIDTH  write data from initiator.
- t_dat_r  out  DATA_WIDTH  registered read data to initiator.
- t_cyc  in  1  cycle valid from initiator.
- t_stb  in  1  strobe from initiator.
- t_we  in  1  write enable from initiator.
- t_sel  in  DATA_WIDTH/8  byte selects from initiator.
- t_ack  out  1  registered ack to initiator.
- t_err  out  1  registered error to initiator.
- i_adr  out  ADDR_WIDTH  registered address to interconnect target port.
- i_dat_w  out  DATA_WIDTH  registered write data to interconnect.
- i_dat_r  in  DATA_WIDTH  read data from interconnect.
- i_cyc  out  1  registered cyc to interconnect.
- i_stb  out  1  registered stb to interconnect.
- i_we  out  1  registered we to interconnect.
- i_sel  out  DATA_WIDTH/8  registered sel to interconnect.
- i_ack  in  1  ack from interconnect.
- i_err  in  1  error from interconnect (includes address decode miss).
- timeout  out  1  one-cycle pulse when a timeout fires.

Behaviour:
- Reset (reset=0, asynchronous, any state): state IDLE, count 0.
  - All outputs 0: i_cyc, i_stb, i_we, i_adr, i_dat_w, i_sel, t_ack, t_err, t_dat_r, timeout.
  - In-flight transaction is discarded; no response is issued after reset release.
- IDLE:
  - t_cyc & t_stb sampled high: register t_adr/t_dat_w/t_we/t_sel onto i_*, set i_cyc=i_stb=1, count=0, go to REQ.
  - Otherwise i_cyc=i_stb=0.
- REQ:
  - i_* held stable; count increments each cycle.
  - i_ack | i_err sampled: t_dat_r <= i_dat_r when (i_ack & !i_we), else unchanged.
    - t_err <= i_err; t_ack <= i_ack & !i_err (err wins if both high).
    - i_cyc=i_stb=0; go to RSP.
  - TIMEOUT≠0 and count==TIMEOUT-1 with no response: t_err<=1, t_dat_r<=0, timeout<=1 for one cycle, i_cyc=i_stb=0, go to RSP.
  - Real response in the expiry cycle takes priority over the timeout.
  - t_cyc sampled low (initiator abort): i_cyc=i_stb=0, go to IDLE, no upstream response.
    - An i_ack/i_err in that same cycle is ignored.
- RSP:
  - t_ack or t_err is high for exactly this one cycle; next state IDLE.
  - t_ack/t_err return to 0 on leaving RSP.
  - Requests are not sampled in RSP; the initiator's next request is sampled in the following IDLE cycle.
- Latency: request first sampled at edge E0.
  - i_stb visible after E0.
  - Zero-wait target acks combinationally in that cycle, so RSP is entered at E1 and t_ack is seen after E1.
  - Minimum 2 cycles stb->ack; throughput 1 transaction per 3 cycles.
- i_ack/i_err in IDLE or RSP are ignored.
- Counter width is $clog2(TIMEOUT+1); it never wraps because the timeout fires first.
- Write data, adr, and sel are never modified by the slice; t_dat_r holds its last value between reads.

Test Plan:
- Reset mid-REQ: assert reset=0 while i_cyc=1 -> all outputs 0 immediately; after release, IDLE with no t_ack/t_err.
- Zero-wait read: t_adr=0x1000_0010, target returns 0xDEAD_BEEF with i_ack in first REQ cycle -> i_adr=0x1000_0010, i_we=0; t_ack=1 for one cycle with t_dat_r=0xDEAD_BEEF, 2 cycles after t_stb sampled.
- Write with 3 wait states: t_we=1, t_dat_w=0x1234_5678, t_sel=0x3 -> i_dat_w/i_sel stable for 4 REQ cycles; t_ack one cycle after i_ack; t_dat_r unchanged.
- Decode error plus simultaneous ack/err: i_err alone -> t_err=1, t_ack=0; i_ack=i_err=1 same cycle -> t_err=1, t_ack=0.
- Timeout: TIMEOUT=4, target silent -> i_stb high exactly 4 cycles, then t_err=1, t_dat_r=0, timeout pulse 1 cycle; late i_ack afterwards ignored.
- Abort and back-to-back: drop t_cyc in REQ -> i_cyc=0 next cycle, no t_ack. Initiator re-strobes immediately after t_ack -> second transaction starts in following IDLE cycle, no lost or duplicated access.
